// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared encodings and board constants for the LED pattern blocks
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'd0,
        MODE_ROT_R  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam int unsigned CLK_RUNBER_HZ = 12_000_000;
    localparam int unsigned CLK_POCKET_HZ = 50_000_000;

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - programmable period counter emitting a one-cycle tick
// Load restarts the count with a new period; hold freezes it without losing the partial period.
module led_tick_gen #(
    parameter int unsigned         PERIOD_W     = 26,
    parameter logic [PERIOD_W-1:0] RESET_PERIOD = '1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic                i_hold,
    output logic                o_tick
);

    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_cnt;
    logic                w_wrap;

    assign w_wrap = (r_cnt == r_period);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period <= RESET_PERIOD;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_period <= i_period;
            r_cnt    <= '0;
        end else if (!i_hold) begin
            r_cnt    <= w_wrap ? '0 : r_cnt + PERIOD_W'(1);
        end
    end

    // The tick marks the cycle whose closing edge performs the step.
    assign o_tick = w_wrap && !i_hold && !i_load;

endmodule

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - four-pattern LED bank driver with programmable step period
// Pattern next-state logic lives here; timing comes from led_tick_gen.
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int unsigned         LED_NUM        = 8,
    parameter int unsigned         CLK_FREQ_HZ    = CLK_RUNBER_HZ,
    parameter int unsigned         PERIOD_W       = 26,
    parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = PERIOD_W'(CLK_FREQ_HZ / 2 - 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                cfg_load,
    input  logic                pause,
    output logic [LED_NUM-1:0]  led,
    output logic                step_pulse
);

    localparam logic [LED_NUM-1:0] LED_LSB = LED_NUM'(1);
    localparam logic [LED_NUM-1:0] LED_MSB = {1'b1, {(LED_NUM-1){1'b0}}};

    mode_e              r_mode;
    dir_e               r_dir;
    logic [LED_NUM-1:0] r_led;
    logic               r_step;

    logic               w_tick;
    logic [LED_NUM-1:0] w_seed;
    logic [LED_NUM-1:0] w_shl;
    logic [LED_NUM-1:0] w_shr;
    logic [LED_NUM-1:0] w_led_next;
    dir_e               w_dir_next;

    led_tick_gen #(
        .PERIOD_W     (PERIOD_W),
        .RESET_PERIOD (DEFAULT_PERIOD)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .i_load   (cfg_load),
        .i_period (period_i),
        .i_hold   (pause),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_seed = LED_LSB;
        case (mode_e'(mode_i))
            MODE_ROT_L:  w_seed = LED_LSB;
            MODE_ROT_R:  w_seed = LED_MSB;
            MODE_BOUNCE: w_seed = LED_LSB;
            MODE_FILL:   w_seed = '0;
            default:     w_seed = LED_LSB;
        endcase
    end

    assign w_shl = {r_led[LED_NUM-2:0], 1'b0};
    assign w_shr = {1'b0, r_led[LED_NUM-1:1]};

    // Bounce flips direction on reaching an end so the end LED is never shown twice.
    always_comb begin
        w_led_next = r_led;
        w_dir_next = r_dir;
        case (r_mode)
            MODE_ROT_L: w_led_next = {r_led[LED_NUM-2:0], r_led[LED_NUM-1]};
            MODE_ROT_R: w_led_next = {r_led[0], r_led[LED_NUM-1:1]};
            MODE_BOUNCE: begin
                if (r_dir == DIR_LEFT) begin
                    w_led_next = w_shl;
                    w_dir_next = w_shl[LED_NUM-1] ? DIR_RIGHT : DIR_LEFT;
                end else begin
                    w_led_next = w_shr;
                    w_dir_next = w_shr[0] ? DIR_LEFT : DIR_RIGHT;
                end
            end
            MODE_FILL: w_led_next = (&r_led) ? '0 : {r_led[LED_NUM-2:0], 1'b1};
            default:   w_led_next = r_led;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= MODE_ROT_L;
            r_dir  <= DIR_LEFT;
            r_led  <= LED_LSB;
            r_step <= 1'b0;
        end else if (cfg_load) begin
            r_mode <= mode_e'(mode_i);
            r_dir  <= DIR_LEFT;
            r_led  <= w_seed;
            r_step <= 1'b0;
        end else if (w_tick) begin
            r_dir  <= w_dir_next;
            r_led  <= w_led_next;
            r_step <= 1'b1;
        end else begin
            r_step <= 1'b0;
        end
    end

    assign led        = r_led;
    assign step_pulse = r_step;

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - scoreboard bench for led_pattern_engine
module tb_led_pattern_engine;

    localparam int N     = 8;
    localparam int PW    = 26;
    localparam int FREQ  = 200;
    localparam int DEF_P = FREQ / 2 - 1;

    typedef struct {
        int          stamp;
        logic [N-1:0] led;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode_i = 2'd0;
    logic [PW-1:0] period_i = '0;
    logic          cfg_load = 1'b0;
    logic          pause = 1'b0;
    logic [N-1:0]  led;
    logic          step_pulse;

    int vectors = 0;
    int miscompares = 0;
    int edge_n = 0;
    bit mon_en = 1'b0;

    int           m_mode;
    int           m_period;
    int           m_active;
    int           m_k;
    logic [N-1:0] m_led;
    exp_t         sb[$];

    led_pattern_engine #(
        .LED_NUM     (N),
        .CLK_FREQ_HZ (FREQ),
        .PERIOD_W    (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_i     (mode_i),
        .period_i   (period_i),
        .cfg_load   (cfg_load),
        .pause      (pause),
        .led        (led),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    // Closed-form pattern: value shown after k steps from the seed of a mode.
    function automatic logic [N-1:0] pattern(input int mode, input int k);
        logic [N-1:0] one;
        int p;
        one = N'(1);
        case (mode)
            0: return one << (k % N);
            1: return one << (N - 1 - (k % N));
            2: begin
                p = k % (2 * (N - 1));
                return one << ((p < N) ? p : 2 * (N - 1) - p);
            end
            default: begin
                p = k % (N + 1);
                return (p == N) ? {N{1'b1}} : ((one << p) - one);
            end
        endcase
    endfunction

    task automatic apply(input bit r, input bit ld, input bit ps, input int md, input int pd);
        rst      = r;
        cfg_load = ld;
        pause    = ps;
        mode_i   = 2'(md);
        period_i = PW'(pd);
        @(posedge clk);
        #1;
        edge_n++;
        if (r) begin
            m_mode = 0; m_period = DEF_P; m_active = 0; m_k = 0;
            m_led = pattern(0, 0);
            sb.delete();
            mon_en = 1'b1;
        end else if (ld) begin
            m_mode = md; m_period = pd; m_active = 0; m_k = 0;
            m_led = pattern(md, 0);
        end else if (!ps) begin
            m_active++;
            if (m_active % (m_period + 1) == 0) begin
                m_k++;
                m_led = pattern(m_mode, m_k);
                sb.push_back('{stamp: edge_n, led: m_led});
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if (led !== m_led) begin
                miscompares++;
                $display("FAIL led_level edge=%0d got=%h expected=%h", edge_n, led, m_led);
            end
            if (step_pulse === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL step_unexpected edge=%0d got=1 expected=0", edge_n);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.stamp != edge_n || led !== e.led) begin
                        miscompares++;
                        $display("FAIL step edge=%0d got=%h expected=%h at edge %0d",
                                 edge_n, led, e.led, e.stamp);
                    end
                end
            end else if (step_pulse !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL step_x edge=%0d got=%b expected=0/1", edge_n, step_pulse);
            end else if (sb.size() != 0 && sb[0].stamp <= edge_n) begin
                vectors++;
                miscompares++;
                $display("FAIL step_missed edge=%0d got=0 expected=1", edge_n);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        // Reset held, then default period runs to its first step.
        for (int i = 0; i < 3; i++) apply(1, 0, 0, 0, 0);
        for (int i = 0; i < DEF_P + 4; i++) apply(0, 0, 0, 0, 0);

        // Directed walk through every mode.
        apply(0, 1, 0, 0, 3);
        for (int i = 0; i < 40; i++) apply(0, 0, 0, 0, 0);
        apply(0, 1, 0, 1, 0);
        for (int i = 0; i < 10; i++) apply(0, 0, 0, 0, 0);
        apply(0, 1, 0, 2, 1);
        for (int i = 0; i < 34; i++) apply(0, 0, 0, 0, 0);
        apply(0, 1, 0, 3, 0);
        for (int i = 0; i < 12; i++) apply(0, 0, 0, 0, 0);

        // Pause landing at cnt = 2 of period 3.
        apply(0, 1, 0, 0, 3);
        apply(0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) apply(0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) apply(0, 0, 0, 0, 0);

        // Load coinciding with a due step, then reset mid-bounce.
        apply(0, 1, 0, 2, 3);
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0);
        apply(0, 1, 0, 3, 2);
        for (int i = 0; i < 8; i++) apply(0, 0, 0, 0, 0);
        apply(0, 1, 0, 2, 0);
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) apply(0, 0, 0, 0, 0);

        // Randomised interleaving of loads, pauses and resets.
        for (int i = 0; i < 4000; i++) begin
            bit r, ld, ps;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 39) == 0);
            ps = ($urandom_range(0, 5) == 0);
            apply(r, ld, ps, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
        end

        apply(0, 1, 0, 1, 2);
        for (int i = 0; i < 20; i++) apply(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_steps got=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
